rca_seq_ctrl: RTL and testbench

//  Sequencer that computes a WIDTH-bit add or subtract on the shared 4-bit ripple-carry adder (RCA_4bit).
//  It processes one nibble per clock and chains the carry through a register.
//  It sits between a valid/ready operand source and a valid/ready result sink.

---
 rtl/rca_pkg.sv | 20 ++
 rtl/rca_seq_ctrl_if.sv | 35 +++
 rtl/rca_seq_ctrl_rca4.sv | 29 ++
 rtl/rca_seq_ctrl.sv | 103 ++++++++++
 tb/tb_rca_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
//----------------------------------------------------------------------------
// Module      : rca_pkg
// Description : Shared state encoding and nibble width for the RCA sequencer.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package rca_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rca_seq_ctrl_if.sv
//----------------------------------------------------------------------------
// Module      : rca_seq_ctrl_if
// Description : Operand/result valid-ready bundle for the RCA sequencer.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface rca_seq_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );
endinterface

`default_nettype wire

// File: rtl/rca_seq_ctrl_rca4.sv
//----------------------------------------------------------------------------
// Module      : RCA_4bit
// Description : 4-bit ripple-carry adder built from full-adder cells.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module RCA_4bit (
   input  wire logic [3:0] x,
   input  wire logic [3:0] y,
   input  wire logic       cin,
   output logic      [3:0] sum,
   output logic            cout
);

   logic [4:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
      assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
   end

   assign cout = w_c[4];

endmodule

`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
//----------------------------------------------------------------------------
// Module      : rca_seq_ctrl
// Description : Nibble-serial WIDTH-bit add/subtract on one shared RCA_4bit.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module rca_seq_ctrl
   import rca_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   rca_seq_ctrl_if.slave  bus
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] c_last = IDX_W'(NIB - 1);

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_carry;
   logic [WIDTH-1:0]      r_a;
   logic [WIDTH-1:0]      r_b;
   logic [WIDTH-1:0]      r_sum;
   logic                  r_cout;
   logic                  r_ovf;
   logic                  r_out_valid;

   logic [NIBBLE_W-1:0]   w_x;
   logic [NIBBLE_W-1:0]   w_y;
   logic [NIBBLE_W-1:0]   w_nsum;
   logic                  w_ncout;

   assign w_x = r_a[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
   assign w_y = r_b[int'(r_idx)*NIBBLE_W +: NIBBLE_W];

   RCA_4bit u_rca (
      .x    (w_x),
      .y    (w_y),
      .cin  (r_carry),
      .sum  (w_nsum),
      .cout (w_ncout)
   );

   // r_b holds b already inverted for subtract, so ovf sees the effective operand
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a;
                  r_b     <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.sub ? 1'b1 : bus.cin;
                  r_idx   <= '0;
                  r_state <= S_ADD;
               end
            end
            S_ADD: begin
               r_sum[int'(r_idx)*NIBBLE_W +: NIBBLE_W] <= w_nsum;
               r_carry <= w_ncout;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == c_last) begin
                  r_cout      <= w_ncout;
                  r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                 (w_nsum[NIBBLE_W-1] != r_a[WIDTH-1]);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
//----------------------------------------------------------------------------
// Module      : tb_rca_seq_ctrl
// Description : Directed self-checking bench for rca_seq_ctrl at WIDTH=16.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_rca_seq_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rca_seq_ctrl_if #(.WIDTH(16)) bus ();

   rca_seq_ctrl #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one op, wait for out_valid (bounded), optionally complete the handshake.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input bit ack,
                         output logic [15:0] s, output logic co, output logic ov,
                         output int lat);
      bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         lat++;
         if (bus.out_valid) break;
      end
      if (!bus.out_valid) lat = -1;
      s = bus.sum; co = bus.cout; ov = bus.ovf;
      if (ack) begin
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0 || bus.cout !== 1'b0 ||
          bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got ov=%b sum=%h cout=%b ovf=%b busy=%b, want 0 0000 0 0 0",
                  bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.busy);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_add();
      logic [15:0] s; logic co, ov; int lat;
      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL add_latency: got %0d want 4", lat);
      end
      checks++;
      if (s !== 16'h5555 || co !== 1'b0 || ov !== 1'b0) begin
         errors++;
         $display("FAIL add_result: got %h/%b/%b want 5555/0/0", s, co, ov);
      end
   endtask

   task automatic test_carry();
      logic [15:0] s; logic co, ov; int lat;
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4 || s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL carry_ffff: got lat=%0d %h/%b/%b want 4 0000/1/0", lat, s, co, ov);
      end
      run_op(16'h000F, 16'h0000, 1'b1, 1'b0, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4 || s !== 16'h0010 || co !== 1'b0 || ov !== 1'b0) begin
         errors++;
         $display("FAIL carry_cin: got lat=%0d %h/%b/%b want 4 0010/0/0", lat, s, co, ov);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] s; logic co, ov; int lat;
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4 || s !== 16'h8000 || co !== 1'b0 || ov !== 1'b1) begin
         errors++;
         $display("FAIL ovf_add: got lat=%0d %h/%b/%b want 4 8000/0/1", lat, s, co, ov);
      end
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4 || s !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sub: got lat=%0d %h/%b/%b want 4 7fff/1/1", lat, s, co, ov);
      end
   endtask

   task automatic test_sub();
      logic [15:0] s; logic co, ov; int lat;
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4 || s !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0) begin
         errors++;
         $display("FAIL sub_borrow: got lat=%0d %h/%b/%b want 4 fffe/0/0", lat, s, co, ov);
      end
      run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4 || s !== 16'h0002 || co !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL sub_noborrow: got lat=%0d %h/%b/%b want 4 0002/1/0", lat, s, co, ov);
      end
   endtask

   task automatic test_handshake();
      int lat;
      bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      // New operands and in_valid during ADD must not disturb the op in flight
      bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1; bus.sub = 1'b1;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = ~bus.in_valid;
         @(posedge clk); #1;
         lat++;
         if (bus.out_valid) break;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (lat !== 4 || bus.sum !== 16'h5555) begin
         errors++;
         $display("FAIL hs_ignore_inputs: got lat=%0d sum=%h want 4 5555", lat, bus.sum);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
             bus.sum !== 16'h5555 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL hs_hold_%0d: got ov=%b rdy=%b busy=%b sum=%h want 1 0 1 5555",
                     i, bus.out_valid, bus.in_ready, bus.busy, bus.sum);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 16'h5555) begin
         errors++;
         $display("FAIL hs_release: got ov=%b rdy=%b sum=%h want 0 1 5555",
                  bus.out_valid, bus.in_ready, bus.sum);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] s; logic co, ov; int lat;
      run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4 || s !== 16'h3333 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: got lat=%0d sum=%h rdy=%b want 4 3333 1", lat, s, bus.in_ready);
      end
      run_op(16'hA000, 16'h6000, 1'b0, 1'b0, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4 || s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: got lat=%0d %h/%b/%b want 4 0000/1/0", lat, s, co, ov);
      end
   endtask

   task automatic test_reset_midop();
      logic [15:0] s; logic co, ov; int lat;
      bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (bus.busy !== 1'b1 || bus.sum[7:0] !== 8'h55) begin
         errors++;
         $display("FAIL midop_progress: got busy=%b sum=%h want 1 xx55", bus.busy, bus.sum);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL midop_abort: got ov=%b sum=%h busy=%b want 0 0000 0",
                  bus.out_valid, bus.sum, bus.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, s, co, ov, lat);
      checks++;
      if (lat !== 4 || s !== 16'h5555 || co !== 1'b0 || ov !== 1'b0) begin
         errors++;
         $display("FAIL midop_recover: got lat=%0d %h/%b/%b want 4 5555/0/0", lat, s, co, ov);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_carry();
      test_overflow();
      test_sub();
      test_handshake();
      test_back_to_back();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
